// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences CPU loads/stores onto a single-port data memory
// with a 1-cycle read latency. It generates byte-lane write enables and
// lane-aligned store data, and returns the raw load word plus its byte offset
// to the downstream sign/zero extender.
//
// Optional feature, selected by the macro DMEM_SPLIT_EN:
//   defined   - misaligned half/word accesses are split into two word beats and
//               load beats are merged; resp_err is never raised.
//   undefined - misaligned accesses are accepted but never touch memory; they
//               complete one cycle later with resp_err=1 and resp_rdata=0.
module dmem_access_ctrl #(
   parameter int unsigned AW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          mem_en,
   output logic [3:0]    mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_din,
   input  logic [31:0]   mem_dout,
   output logic          resp_valid,
   output logic [31:0]   resp_rdata,
   output logic [1:0]    resp_addr_lo,
   output logic [2:0]    resp_funct3,
   output logic          resp_err
);

`ifdef DMEM_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StBeat1, StBeat2} state_e;

   state_e        state_q;
   logic          we_q;
   logic [2:0]    funct3_q;
   logic [AW-1:0] word_q;
   logic [1:0]    k_q;
   logic [31:0]   wdata_q;
   logic          mis_q;
   logic [31:0]   w1_q;

   logic [1:0]    req_k;
   logic          req_mis;
   logic [3:0]    req_lanes;
   logic [31:0]   req_din;

   logic [5:0]    b2_shift;
   logic [3:0]    b2_lanes;
   logic [31:0]   b2_din;
   logic [AW-1:0] word_next;
   logic [63:0]   merge_pair;
   logic          unused_bits;

   assign req_k = req_addr[1:0];

   // Decode the incoming request: misalignment, first-beat lanes and store data.
   always_comb begin
      req_mis   = 1'b0;
      req_lanes = 4'b0000;
      req_din   = 32'h0;
      case (req_funct3[1:0])
         2'b00: begin
            req_lanes = 4'b0001 << req_k;
            req_din   = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            // 0011<<3 truncates to 1000, which is also the misaligned first-beat mask.
            req_lanes = 4'b0011 << req_k;
            req_mis   = (req_k == 2'd3);
            req_din   = req_mis ? (req_wdata << 24) : {2{req_wdata[15:0]}};
         end
         default: begin
            req_lanes = 4'b1111 << req_k;
            req_mis   = (req_k != 2'd0);
            req_din   = req_wdata << {req_k, 3'b000};
         end
      endcase
   end

   // Second-beat lanes/data carry the bytes that spilled past the first word.
   assign b2_shift   = 6'd32 - {1'b0, k_q, 3'b000};
   assign b2_din     = wdata_q >> b2_shift;
   assign b2_lanes   = (funct3_q[1:0] == 2'b01) ? 4'b0001 : (4'b1111 >> (3'd4 - {1'b0, k_q}));
   // Incrementing the word address wraps naturally at 2**AW.
   assign word_next  = word_q + {{(AW-1){1'b0}}, 1'b1};
   assign merge_pair = {mem_dout, w1_q} >> {k_q, 3'b000};

   assign unused_bits = ^{req_addr[31:AW+2], merge_pair[63:32]};

   // Output decode; everything is forced low while reset is asserted.
   always_comb begin
      req_ready    = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 4'b0000;
      mem_addr     = '0;
      mem_din      = 32'h0;
      resp_valid   = 1'b0;
      resp_rdata   = 32'h0;
      resp_addr_lo = 2'd0;
      resp_funct3  = 3'd0;
      resp_err     = 1'b0;
      if (!rst) begin
         case (state_q)
            StIdle: begin
               req_ready = 1'b1;
               // Without splitting, a misaligned request is accepted but never reaches memory.
               if (req_valid && (SplitEn || !req_mis)) begin
                  mem_en   = 1'b1;
                  mem_addr = req_addr[AW+1:2];
                  if (req_we) begin
                     mem_we  = req_lanes;
                     mem_din = req_din;
                  end
               end
            end
            StBeat1: begin
               if (mis_q && SplitEn) begin
                  mem_en   = 1'b1;
                  mem_addr = word_next;
                  if (we_q) begin
                     mem_we  = b2_lanes;
                     mem_din = b2_din;
                  end
               end else begin
                  resp_valid  = 1'b1;
                  resp_funct3 = funct3_q;
                  resp_err    = mis_q && !SplitEn;
                  if (!mis_q) begin
                     resp_addr_lo = k_q;
                     if (!we_q) begin
                        resp_rdata = mem_dout;
                     end
                  end
               end
            end
            StBeat2: begin
               resp_valid  = 1'b1;
               resp_funct3 = funct3_q;
               // The merged word is already shifted into place, so the offset reads as 0.
               if (!we_q) begin
                  resp_rdata = merge_pair[31:0];
               end
            end
            default: begin
               req_ready = 1'b0;
            end
         endcase
      end
   end

   // Access FSM plus the request fields latched on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         word_q   <= '0;
         k_q      <= 2'd0;
         wdata_q  <= 32'h0;
         mis_q    <= 1'b0;
         w1_q     <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  word_q   <= req_addr[AW+1:2];
                  k_q      <= req_k;
                  wdata_q  <= req_wdata;
                  mis_q    <= req_mis;
                  state_q  <= StBeat1;
               end
            end
            StBeat1: begin
               if (mis_q && SplitEn) begin
                  w1_q    <= mem_dout;
                  state_q <= StBeat2;
               end else begin
                  state_q <= StIdle;
               end
            end
            StBeat2: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a byte-level reference memory plus per-cycle
// expected outputs derived from access size/offset, compared every cycle,
// and a set of literal spot checks.
module tb_dmem_access_ctrl;
   localparam int unsigned AW = 14;
`ifdef DMEM_SPLIT_EN
   localparam bit Split = 1'b1;
`else
   localparam bit Split = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic [31:0]   mem_dout;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic [1:0]    resp_addr_lo;
   logic [2:0]    resp_funct3;
   logic          resp_err;

   dmem_access_ctrl #(.AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_addr_lo (resp_addr_lo),
      .resp_funct3  (resp_funct3),
      .resp_err     (resp_err)
   );

   typedef struct {
      bit          ready;
      bit          en;
      logic [3:0]  we;
      logic [13:0] addr;
      bit          chk_din;
      logic [31:0] din;
      bit          rv;
      logic [31:0] rdata;
      bit          chk_lo;
      logic [1:0]  lo;
      logic [2:0]  f3;
      bit          err;
   } exp_t;

   typedef struct {
      logic        vin;
      logic        ready;
      logic        en;
      logic [3:0]  we;
      logic [13:0] addr;
      logic [31:0] din;
      logic        rv;
      logic [31:0] rdata;
      logic [1:0]  lo;
      logic        err;
   } obs_t;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   exp_t exp_q[$];
   obs_t obs [int];
   logic [31:0] emem [int];
   logic [7:0]  ref_b [int];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rdw(input int w);
      return emem.exists(w) ? emem[w] : 32'h0;
   endfunction

   function automatic logic [7:0] rb(input int a);
      int m;
      m = a & 'hFFFF;
      return ref_b.exists(m) ? ref_b[m] : 8'h00;
   endfunction

   task automatic preload(input int w, input logic [31:0] v);
      emem[w] = v;
      for (int i = 0; i < 4; i++) ref_b[w*4 + i] = v[8*i +: 8];
   endtask

   // Data memory with one cycle of read latency, read-before-write.
   always @(posedge clk) begin : env_mem
      logic [31:0] w;
      if (mem_en) begin
         w = rdw(int'(mem_addr));
         mem_dout <= w;
         for (int i = 0; i < 4; i++) if (mem_we[i]) w[8*i +: 8] = mem_din[8*i +: 8];
         if (|mem_we) emem[int'(mem_addr)] = w;
      end
   end

   // Per-cycle comparison against the expectation queue.
   always @(negedge clk) begin : compare
      obs_t o;
      exp_t e;
      o.vin = req_valid; o.ready = req_ready; o.en = mem_en; o.we = mem_we;
      o.addr = mem_addr; o.din = mem_din; o.rv = resp_valid; o.rdata = resp_rdata;
      o.lo = resp_addr_lo; o.err = resp_err;
      obs[cyc] = o;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check($sformatf("c%0d_req_ready", cyc), 64'(req_ready), 64'(e.ready));
         check($sformatf("c%0d_mem_en", cyc), 64'(mem_en), 64'(e.en));
         check($sformatf("c%0d_mem_we", cyc), 64'(mem_we), 64'(e.we));
         if (e.en) check($sformatf("c%0d_mem_addr", cyc), 64'(mem_addr), 64'(e.addr));
         if (e.chk_din) check($sformatf("c%0d_mem_din", cyc), 64'(mem_din), 64'(e.din));
         check($sformatf("c%0d_resp_valid", cyc), 64'(resp_valid), 64'(e.rv));
         if (e.rv) begin
            check($sformatf("c%0d_resp_rdata", cyc), 64'(resp_rdata), 64'(e.rdata));
            check($sformatf("c%0d_resp_funct3", cyc), 64'(resp_funct3), 64'(e.f3));
            check($sformatf("c%0d_resp_err", cyc), 64'(resp_err), 64'(e.err));
         end
         if (e.chk_lo) check($sformatf("c%0d_resp_addr_lo", cyc), 64'(resp_addr_lo), 64'(e.lo));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exp_t e;
      e = '{default: '0};
      req_valid = 1'b0;
      e.ready = 1'b1;
      exp_q.push_back(e);
      step();
   endtask

   // Issue one access and queue what every cycle of it must look like.
   task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, output int ac);
      exp_t e;
      int k, sz, word;
      bit mis;
      logic [31:0] ld, din1, din2;
      logic [3:0] we1, we2;
      k    = int'(addr[1:0]);
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis  = (k + sz > 4);
      word = int'(addr[15:2]);
      ld = 32'h0; din1 = 32'h0; din2 = 32'h0; we1 = 4'h0; we2 = 4'h0;
      for (int i = 0; i < 4; i++) ld[8*i +: 8] = mis ? rb(int'(addr) + i) : rb(word*4 + i);
      for (int j = 0; j < 4; j++) begin
         if (j >= k && j < k + sz) we1[j] = 1'b1;
         if (j < k + sz - 4) we2[j] = 1'b1;
      end
      if (!mis) begin
         din1 = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (j >= k) din1[8*j +: 8] = wd[8*(j-k) +: 8];
            if (j + 4 - k < 4) din2[8*j +: 8] = wd[8*(j+4-k) +: 8];
         end
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      ac = cyc;
      e = '{default: '0};
      e.ready = 1'b1;
      e.en = !mis || Split;
      e.addr = addr[15:2];
      if (we && e.en) begin e.we = we1; e.chk_din = 1'b1; e.din = din1; end
      exp_q.push_back(e);
      step();
      if (!hold) req_valid = 1'b0;
      e = '{default: '0};
      if (mis && !Split) begin
         e.rv = 1'b1; e.err = 1'b1; e.f3 = f3; e.rdata = 32'h0;
      end else if (mis) begin
         e.en = 1'b1;
         e.addr = 14'(word + 1);
         if (we) begin e.we = we2; e.chk_din = 1'b1; e.din = din2; end
         exp_q.push_back(e);
         step();
         e = '{default: '0};
         e.rv = 1'b1; e.f3 = f3; e.rdata = we ? 32'h0 : ld; e.chk_lo = !we; e.lo = 2'd0;
      end else begin
         e.rv = 1'b1; e.f3 = f3; e.rdata = we ? 32'h0 : ld; e.chk_lo = !we; e.lo = addr[1:0];
      end
      exp_q.push_back(e);
      step();
      if (we && (!mis || Split))
         for (int i = 0; i < sz; i++) ref_b[(int'(addr) + i) & 'hFFFF] = wd[8*i +: 8];
   endtask

   initial begin : stim
      int a;
      int n;
      exp_t e;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0; mem_dout = 32'h0;
      preload(32'h40, 32'hDEADBEEF);
      preload(32'h3FFF, 32'h11223344);
      preload(32'h0, 32'h55667788);

      // Reset holds every output low even with a request pending.
      repeat (2) @(posedge clk);
      #1;
      req_valid = 1'b1; req_addr = 32'h100; req_funct3 = 3'b010;
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_mem_en", 64'(mem_en), 64'h0);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0; req_valid = 1'b0;
      a = cyc;
      idle();
      check("post_rst_ready", 64'(obs[a].ready), 64'h1);

      access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, a);
      check("lw100_rdata", 64'(obs[a+1].rdata), 64'hDEADBEEF);
      check("lw100_lo", 64'(obs[a+1].lo), 64'h0);
      access(1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b0, a);
      check("sb103_we", 64'(obs[a].we), 64'b1000);
      check("sb103_din", 64'(obs[a].din), 64'hA5A5A5A5);
      check("sb103_addr", 64'(obs[a].addr), 64'h40);
      access(1'b1, 3'b001, 32'h102, 32'h00001234, 1'b0, a);
      check("sh102_we", 64'(obs[a].we), 64'b1100);
      check("sh102_din_hi", 64'(obs[a].din[31:16]), 64'h1234);
      access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, a);
      check("lw100_after_st", 64'(obs[a+1].rdata), 64'h1234BEEF);
      idle();

      preload(32'h40, 32'h33221100);
      preload(32'h41, 32'h77665544);
      access(1'b0, 3'b010, 32'h101, 32'h0, 1'b0, a);
`ifdef DMEM_SPLIT_EN
      check("lw101_beat1_no_resp", 64'(obs[a+1].rv), 64'h0);
      check("lw101_merge", 64'(obs[a+2].rdata), 64'h44332211);
`else
      check("lw101_no_access", 64'(obs[a].en), 64'h0);
      check("lw101_err", 64'(obs[a+1].err), 64'h1);
`endif
      access(1'b1, 3'b010, 32'h103, 32'hAABBCCDD, 1'b0, a);
`ifdef DMEM_SPLIT_EN
      check("sw103_b1_we", 64'(obs[a].we), 64'b1000);
      check("sw103_b1_din", 64'(obs[a].din[31:24]), 64'hDD);
      check("sw103_b2_addr", 64'(obs[a+1].addr), 64'h41);
      check("sw103_b2_we", 64'(obs[a+1].we), 64'b0111);
      check("sw103_b2_din", 64'(obs[a+1].din[23:0]), 64'hAABBCC);
`endif
      access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, a);
      access(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, a);

      access(1'b0, 3'b001, 32'hFFFF, 32'h0, 1'b0, a);
`ifdef DMEM_SPLIT_EN
      check("lh_wrap_addr", 64'(obs[a+1].addr), 64'h0);
      check("lh_wrap_rdata", 64'(obs[a+2].rdata), 64'h66778811);
`endif
      access(1'b1, 3'b001, 32'hFFFF, 32'h0000BEEF, 1'b0, a);
      access(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, a);

      access(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, a);
`ifndef DMEM_SPLIT_EN
      check("lw102_no_access", 64'(obs[a].en), 64'h0);
      check("lw102_err", 64'(obs[a+1].err), 64'h1);
      check("lw102_rdata", 64'(obs[a+1].rdata), 64'h0);
`endif

      for (int k = 0; k < 4; k++) access(1'b1, 3'b000, 32'h200 + k, 32'h10 + k, 1'b0, a);
      access(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, a);
      check("sb_sweep_word", 64'(obs[a+1].rdata), 64'h13121110);
      for (int k = 0; k < 4; k++) access(1'b0, 3'b100, 32'h200 + k, 32'h0, 1'b0, a);
      access(1'b1, 3'b001, 32'h204, 32'h0000CAFE, 1'b0, a);
      access(1'b1, 3'b001, 32'h206, 32'h0000F00D, 1'b0, a);
      access(1'b0, 3'b010, 32'h204, 32'h0, 1'b0, a);
      check("sh_pair_word", 64'(obs[a+1].rdata), 64'hF00DCAFE);
      access(1'b1, 3'b010, 32'h208, 32'h01234567, 1'b0, a);
      access(1'b0, 3'b101, 32'h20A, 32'h0, 1'b0, a);
      access(1'b0, 3'b010, 32'h205, 32'h0, 1'b0, a);
      idle();

      // Reset during the first beat of a misaligned load: no response.
      a = cyc;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h101;
      e = '{default: '0};
      e.ready = 1'b1; e.en = Split; e.addr = 14'h40;
      exp_q.push_back(e);
      step();
      rst = 1'b1; req_valid = 1'b0;
      e = '{default: '0};
      exp_q.push_back(e);
      step();
      rst = 1'b0;
      idle();
      idle();
      check("rst_mid_no_resp", 64'(obs[a+1].rv), 64'h0);
      check("rst_mid_ready", 64'(obs[a+2].ready), 64'h1);
      check("rst_mid_no_resp2", 64'(obs[a+2].rv), 64'h0);

      // req_valid held high: accepted only on alternate cycles.
      access(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, a);
      n = a;
      access(1'b0, 3'b010, 32'h204, 32'h0, 1'b1, a);
      access(1'b0, 3'b100, 32'h201, 32'h0, 1'b1, a);
      idle();
      a = 0;
      for (int c = n; c < n + 6; c++) if (obs[c].vin && obs[c].ready) a++;
      check("held_accepts", 64'(a), 64'd3);

      idle();
      @(negedge clk);
      #1;
      check("exp_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
